mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter sharing the single RAM port between the instruction-fetch path and the data-memory path of the MIPS core. It accepts one request per side, grants the RAM to one requester at a time, and holds the RAM strobes until the RAM reports completion. It then returns load data with a one-cycle hit pulse. It sits between the datapath (PC/fetch and the MemRead/MemWrite stage driven by the control unit) and the RAM model.

## Interface
- `DATA_W`, 32: data and address width.
- `STARVE_MAX`, 4: number of consecutive data grants after which a pending instruction request wins.
- `TIMEOUT`, 64: cycles to wait for `ramready` before forcing completion (only with `ARB_TIMEOUT_EN`).

Ports:
- `CLK`  in  1  clock, rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `iREN`  in  1  instruction read request; held until `ihit`.
- `iaddr`  in  DATA_W  instruction address.
- `iload`  out  DATA_W  instruction data; valid while `ihit`=1.
- `ihit`  out  1  one-cycle completion pulse for instruction.
- `dREN` / `dWEN`  in  1 / 1  data read / write request; held until `dhit`.
- `daddr`, `dstore`  in  DATA_W  data address and write data.
- `dload`  out  DATA_W  data read result; valid while `dhit`=1.
- `dhit`  out  1  one-cycle completion pulse for data.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`, `ramstore`  out  DATA_W  RAM address and write data.
- `ramload`  in  DATA_W  RAM read data.
- `ramready`  in  1  RAM access complete this cycle.
- `timeout_err`  out  1  sticky; set on watchdog expiry (tied 0 without `ARB_TIMEOUT_EN`).

## Operation
- States: `IDLE`, `IGNT`, `DGNT`, `DONE`.
- `IDLE`:
  - If `dWEN` or `dREN` is pending, go to `DGNT`. The exception: `iREN` is pending and the starvation counter equals `STARVE_MAX`; then go to `IGNT`.
  - Else if `iREN` is pending, go to `IGNT`.
  - Else stay in `IDLE`.
- At the grant edge, latch the address, the write data and the operation into internal registers. `dWEN` and `dREN` together are treated as a write.
- `IGNT` / `DGNT`:
  - Drive `ramaddr`, `ramstore` and `ramREN`/`ramWEN` from the latched registers only. Requester inputs may change freely during the grant.
  - When `ramready`=1, register `ramload` into `iload` or `dload`, set the matching hit, and go to `DONE`.
- `DONE`:
  - The matching hit is 1 for exactly this cycle. The RAM strobes are 0.
  - No grant is made in this cycle. The next state is unconditionally `IDLE`.
- Starvation counter:
  - Increments on a data grant while `iREN`=1, saturating at `STARVE_MAX`.
  - Clears on any instruction grant, and on a data grant while `iREN`=0.
- `iload` and `dload` hold their last value outside hit cycles.
- Reset (synchronous, at the edge with `RST`=1, including mid-grant):
  - State goes to `IDLE`; the starvation counter goes to 0.
  - All outputs go to 0: strobes, hits, `iload`, `dload`, `ramaddr`, `ramstore`, `timeout_err`.
  - Any in-flight access is abandoned and no hit is issued for it.

## Timing
- Request in cycle 0, with the arbiter in `IDLE`:
  - The strobe is asserted in cycle 1.
  - If `ramready` comes in cycle k (k≥1), the hit is in cycle k+1 and `IDLE` is in cycle k+2.
- Minimum request-to-hit latency is 2 cycles. Minimum port occupancy per access is 3 cycles.
- A requester must hold its request and operands until it sees the hit. It may reassert in the cycle after the hit; that request is sampled in `IDLE`.
- `ramready` is ignored outside `IGNT` and `DGNT`.
- Exactly one of `ramREN`/`ramWEN` is high in a grant state. Both are low in all other states.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A cycle counter clears on entry to `IGNT`/`DGNT` and increments each grant cycle without `ramready`.
  - When it reaches `TIMEOUT`, go to `DONE` with hit=1, load data 0xBAD1BAD1 on reads, and set `timeout_err` (sticky until reset).
- Undefined:
  - No counter. The arbiter waits indefinitely for `ramready`. `timeout_err` is constant 0.

## Test plan
- Instruction read only: `iREN`=1, `iaddr`=0x40, RAM returns 0x8C220004 with `ramready` in cycle 1 -> `ramREN`=1 and `ramaddr`=0x40 in cycle 1; `ihit`=1 and `iload`=0x8C220004 in cycle 2.
- Data write with 3 wait states: `dWEN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF, `ramready` in cycle 4 -> `ramWEN`=1 in cycles 1-4; `dhit` in cycle 5; `ramREN`=0 throughout.
- Simultaneous requests: `iREN`=`dREN`=1, starvation counter 0 -> data granted first; instruction granted in the next `IDLE` cycle (cycle 3 with 1-cycle RAM).
- Starvation: `iREN` held and `dREN` reasserted back-to-back, `STARVE_MAX`=4 -> 4 data grants, then the instruction is granted; the counter reads 0 afterward.
- Reset mid-grant: `RST`=1 in cycle 2 of a `DGNT` with no `ramready` -> cycle 3 state `IDLE`, all strobes and hits 0, no `dhit` issued.
- With `ARB_TIMEOUT_EN`, `TIMEOUT`=8, `ramready` never asserted -> `dhit`=1 with `dload`=0xBAD1BAD1 after 8 grant cycles; `timeout_err` stays 1 until `RST`.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester-side and RAM-side bus of the shared memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              iREN;
  logic [DATA_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dREN;
  logic              dWEN;
  logic [DATA_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              ramREN;
  logic              ramWEN;
  logic [DATA_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
  logic              timeout_err;

  // Arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );

  // Requester / RAM model side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one RAM port between instruction fetch and data access.
// Optional watchdog enabled by macro ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  wire logic    CLK,
  input  wire logic    RST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned       C_STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [C_STARVE_W-1:0] C_STARVE_MAX = C_STARVE_W'(STARVE_MAX);
  localparam logic [DATA_W-1:0] C_BAD_DATA   = DATA_W'(32'hBAD1_BAD1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_is_write;
  logic                  r_is_instr;
  logic [C_STARVE_W-1:0] r_starve_cnt;
  logic [DATA_W-1:0]     r_iload;
  logic [DATA_W-1:0]     r_dload;

  logic w_grant_i;
  logic w_grant_d;
  logic w_complete;
  logic w_in_grant;
  logic w_timeout;
  logic w_d_pending;

  assign w_in_grant  = (r_state == IGNT) || (r_state == DGNT);
  assign w_d_pending = bus.dREN || bus.dWEN;

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        // A starved instruction fetch overrides the data-first priority.
        if (w_d_pending && !(bus.iREN && (r_starve_cnt == C_STARVE_MAX))) begin
          w_state_next = DGNT;
          w_grant_d    = 1'b1;
        end else if (bus.iREN) begin
          w_state_next = IGNT;
          w_grant_i    = 1'b1;
        end
      end
      IGNT, DGNT: begin
        if (bus.ramready || w_timeout) begin
          w_state_next = DONE;
          w_complete   = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_is_instr   <= 1'b0;
      r_starve_cnt <= '0;
      r_iload      <= '0;
      r_dload      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i) begin
        r_addr       <= bus.iaddr;
        r_is_write   <= 1'b0;
        r_is_instr   <= 1'b1;
        r_starve_cnt <= '0;
      end
      if (w_grant_d) begin
        r_addr     <= bus.daddr;
        r_wdata    <= bus.dstore;
        r_is_write <= bus.dWEN;
        r_is_instr <= 1'b0;
        if (!bus.iREN) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != C_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + C_STARVE_W'(1);
        end
      end
      if (w_complete) begin
        if (r_is_instr) begin
          r_iload <= w_timeout ? C_BAD_DATA : bus.ramload;
        end else if (!w_timeout) begin
          r_dload <= bus.ramload;
        end else if (!r_is_write) begin
          r_dload <= C_BAD_DATA;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned C_WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [C_WAIT_W-1:0] r_wait_cnt;
  logic                r_timeout_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_grant_i || w_grant_d) begin
        r_wait_cnt <= '0;
      end else if (w_in_grant && !bus.ramready) begin
        r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Fires on the TIMEOUT-th grant cycle without ramready.
  assign w_timeout       = w_in_grant && !bus.ramready &&
                           (r_wait_cnt == C_WAIT_W'(TIMEOUT - 1));
  assign bus.timeout_err = r_timeout_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT;
  assign w_timeout        = 1'b0;
  assign bus.timeout_err  = 1'b0;
`endif

  assign bus.ramREN   = w_in_grant && !r_is_write;
  assign bus.ramWEN   = w_in_grant && r_is_write;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_wdata;
  assign bus.ihit     = (r_state == DONE) && r_is_instr;
  assign bus.dhit     = (r_state == DONE) && !r_is_instr;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if #(.DATA_W(32)) bus ();

  mem_arbiter #(
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TIMEOUT   (8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 0;
    tick(); tick();
    check("rst_state",   32'(dut.r_state), 32'd0);
    check("rst_ramREN",  32'(bus.ramREN), 32'd0);
    check("rst_ramWEN",  32'(bus.ramWEN), 32'd0);
    check("rst_hits",    32'({bus.ihit, bus.dhit}), 32'd0);
    check("rst_iload",   bus.iload, 32'd0);
    check("rst_dload",   bus.dload, 32'd0);
    check("rst_ramaddr", bus.ramaddr, 32'd0);
    check("rst_terr",    32'(bus.timeout_err), 32'd0);
    rst = 1'b0;

    // Instruction read, one-cycle RAM
    bus.iREN = 1; bus.iaddr = 32'h40;
    tick();
    check("i_ramREN",  32'(bus.ramREN), 32'd1);
    check("i_ramWEN",  32'(bus.ramWEN), 32'd0);
    check("i_ramaddr", bus.ramaddr, 32'h40);
    bus.ramready = 1; bus.ramload = 32'h8C220004;
    tick();
    check("i_ihit",   32'(bus.ihit), 32'd1);
    check("i_iload",  bus.iload, 32'h8C220004);
    check("i_done_strobe", 32'(bus.ramREN), 32'd0);
    check("i_dhit",   32'(bus.dhit), 32'd0);
    bus.iREN = 0; bus.ramready = 0; bus.ramload = 32'h0;
    tick();
    check("i_ihit_pulse", 32'(bus.ihit), 32'd0);
    check("i_iload_hold", bus.iload, 32'h8C220004);
    check("i_idle",       32'(dut.r_state), 32'd0);

    // Data write with 3 wait states; requester operands change mid-grant
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("w_ramWEN",   32'(bus.ramWEN), 32'd1);
      check("w_ramREN",   32'(bus.ramREN), 32'd0);
      check("w_ramaddr",  bus.ramaddr, 32'h100);
      check("w_ramstore", bus.ramstore, 32'hDEADBEEF);
      check("w_dhit_early", 32'(bus.dhit), 32'd0);
      if (c == 2) begin
        bus.daddr = 32'h200; bus.dstore = 32'h0;
      end
      if (c == 4) bus.ramready = 1;
    end
    tick();
    check("w_dhit",   32'(bus.dhit), 32'd1);
    check("w_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    bus.dWEN = 0; bus.ramready = 0;
    tick();
    check("w_dhit_pulse", 32'(bus.dhit), 32'd0);

    // Simultaneous requests: data first, instruction next
    bus.iREN = 1; bus.iaddr = 32'h44; bus.dREN = 1; bus.daddr = 32'h104;
    bus.ramready = 1; bus.ramload = 32'h11111111;
    tick();
    check("s_d_ramREN",  32'(bus.ramREN), 32'd1);
    check("s_d_ramaddr", bus.ramaddr, 32'h104);
    tick();
    check("s_dhit",  32'(bus.dhit), 32'd1);
    check("s_dload", bus.dload, 32'h11111111);
    check("s_ihit0", 32'(bus.ihit), 32'd0);
    bus.dREN = 0; bus.ramload = 32'h22222222;
    tick();
    check("s_idle_strobe", 32'(bus.ramREN), 32'd0);
    check("s_idle_ihit",   32'(bus.ihit), 32'd0);
    tick();
    check("s_i_ramREN",  32'(bus.ramREN), 32'd1);
    check("s_i_ramaddr", bus.ramaddr, 32'h44);
    tick();
    check("s_ihit",  32'(bus.ihit), 32'd1);
    check("s_iload", bus.iload, 32'h22222222);
    check("s_dload_hold", bus.dload, 32'h11111111);
    check("s_starve0", 32'(dut.r_starve_cnt), 32'd0);
    bus.iREN = 0; bus.ramready = 0;
    tick();

    // Starvation: four data grants, then the held instruction wins
    bus.iREN = 1; bus.iaddr = 32'h48; bus.dREN = 1; bus.daddr = 32'h200;
    bus.ramready = 1; bus.ramload = 32'h33333333;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("v_d_ramaddr", bus.ramaddr, 32'h200);
      check("v_d_ramREN",  32'(bus.ramREN), 32'd1);
      tick();
      check("v_dhit", 32'(bus.dhit), 32'd1);
      tick();
    end
    check("v_starve_max", 32'(dut.r_starve_cnt), 32'd4);
    tick();
    check("v_i_ramaddr", bus.ramaddr, 32'h48);
    check("v_i_ramREN",  32'(bus.ramREN), 32'd1);
    check("v_starve_clr", 32'(dut.r_starve_cnt), 32'd0);
    tick();
    check("v_ihit", 32'(bus.ihit), 32'd1);
    bus.iREN = 0; bus.dREN = 0; bus.ramready = 0;
    tick();

    // dREN and dWEN together behave as a write
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h500; bus.dstore = 32'h55;
    bus.ramready = 1;
    tick();
    check("rw_ramWEN", 32'(bus.ramWEN), 32'd1);
    check("rw_ramREN", 32'(bus.ramREN), 32'd0);
    tick();
    check("rw_dhit", 32'(bus.dhit), 32'd1);
    bus.dREN = 0; bus.dWEN = 0; bus.ramready = 0;
    tick();

    // Reset in the middle of a data grant
    bus.dREN = 1; bus.daddr = 32'h300;
    tick();
    check("r_grant", 32'(bus.ramREN), 32'd1);
    tick();
    rst = 1;
    tick();
    check("r_state",   32'(dut.r_state), 32'd0);
    check("r_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
    check("r_hits",    32'({bus.ihit, bus.dhit}), 32'd0);
    check("r_ramaddr", bus.ramaddr, 32'd0);
    check("r_dload",   bus.dload, 32'd0);
    check("r_iload",   bus.iload, 32'd0);
    rst = 0; bus.dREN = 0;
    tick();
    check("r_no_dhit", 32'(bus.dhit), 32'd0);
    check("r_idle",    32'(dut.r_state), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog: ramready never arrives
    bus.dREN = 1; bus.daddr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("t_grant", 32'(bus.ramREN), 32'd1);
      check("t_dhit_early", 32'(bus.dhit), 32'd0);
    end
    tick();
    check("t_dhit",  32'(bus.dhit), 32'd1);
    check("t_dload", bus.dload, 32'hBAD1BAD1);
    check("t_terr",  32'(bus.timeout_err), 32'd1);
    bus.dREN = 0;
    tick(); tick();
    check("t_terr_sticky", 32'(bus.timeout_err), 32'd1);
    rst = 1;
    tick();
    check("t_terr_rst", 32'(bus.timeout_err), 32'd0);
    rst = 0;
`else
    // Without the watchdog the arbiter waits indefinitely
    bus.dREN = 1; bus.daddr = 32'h400;
    for (int c = 1; c <= 12; c++) tick();
    check("n_still_grant", 32'(bus.ramREN), 32'd1);
    check("n_no_dhit",     32'(bus.dhit), 32'd0);
    check("n_terr",        32'(bus.timeout_err), 32'd0);
    bus.ramready = 1; bus.ramload = 32'h77;
    tick();
    check("n_dhit",  32'(bus.dhit), 32'd1);
    check("n_dload", bus.dload, 32'h77);
    bus.dREN = 0; bus.ramready = 0;
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
